task_in_pingpong: RTL and testbench
===================================

Name: task_in_pingpong

Overview:
- Next-generation task input stage: captures AXI-stream-style input frames into two internal banks (ping-pong) and replays each completed frame to the task core with valid/ready backpressure.
- Loading of frame N+1 overlaps sending of frame N; no vendor FIFO IP, memory is inferred.
- Sits between the stream source and the task compute block.
- Adds variable frame length, overflow truncation and downstream stall support.

Parameters:
- DATA_WIDTH, 8, width of input and output words.
- MAX_WORDS, 243, capacity of each bank in words; maximum frame length.
- LEN_WIDTH, $clog2(MAX_WORDS+1), width of the frame-length output; do not override.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_tdata_valid  in  1  input word valid.
- i_tdata  in  DATA_WIDTH  input word.
- i_tdata_last  in  1  last word of frame; qualified by valid&&ready.
- o_tready  out  1  block can accept an input word.
- o_data  out  DATA_WIDTH  output word.
- o_enb  out  1  output word valid.
- o_last  out  1  marks the final word of the frame on o_data.
- i_out_ready  in  1  downstream accepts the word; a transfer occurs on o_enb && i_out_ready.
- o_frame_len  out  LEN_WIDTH  length of the frame currently being sent; held stable while sending.
- o_err_ovf  out  1  one-cycle pulse when a frame is truncated.

Behaviour:
- Reset (async assert, sync release): both banks empty, write and read pointers select bank 0. All outputs reset to 0, including o_tready. Any partial or stored frames are discarded. Reset mid-frame requires no recovery action.
- Bank state: each bank has a full flag and a length register. A write-side commit sets full; a read-side release clears it. Commit and release on different banks in the same cycle are both honoured.
- Write FSM, W_IDLE:
  - o_tready=0.
  - Go to W_LOAD in the next cycle once the write bank is not full.
- Write FSM, W_LOAD:
  - o_tready=1.
  - Each accepted word is stored at wr_cnt, then wr_cnt increments.
  - Accepted word with last: commit the bank with len=wr_cnt+1, toggle the write bank, go to W_IDLE. o_tready drops in the cycle after the last is accepted.
  - Accepted word that fills the bank (wr_cnt=MAX_WORDS-1) without last: go to W_DROP.
- Write FSM, W_DROP:
  - o_tready=1; words are accepted and discarded.
  - On accepted last: commit with len=MAX_WORDS, pulse o_err_ovf, toggle bank, go to W_IDLE.
- Exact fill: a last arriving on word MAX_WORDS is a normal commit with no error.
- last with valid=0 is ignored. A single-word frame has len=1.
- Read FSM, R_IDLE: when the read bank is full, latch o_frame_len and start a 1-cycle-latency memory read. Go to R_SEND.
- Read FSM, R_SEND:
  - o_enb is registered. The first o_enb rises no later than 2 cycles after the bank's commit cycle.
  - While i_out_ready=1, one word is transferred per cycle with no bubbles.
  - With o_enb=1 and i_out_ready=0: o_data, o_last and o_enb hold unchanged.
  - o_last=1 exactly on word len-1.
  - On the last transfer: release the bank, toggle the read bank, return to R_IDLE. Next frame's first o_enb appears within 2 cycles if that bank is full.
- Both banks full: o_tready stays 0 until a release occurs. The input stalls; no data is lost.
- Ordering: frames are output strictly in commit order.

Optional Feature:
- Macro TASK_IN_FRAME_CNT_EN.
- Defined: extra port o_frame_cnt (out, 16 bits) counts frames fully sent. It increments on the last transfer, wraps 0xFFFF->0 and resets to 0. It also adds o_ovf_cnt (out, 8 bits), counting o_err_ovf pulses and saturating at 0xFF.
- Not defined: neither port exists and no counter logic is generated; all other behaviour is identical.

Test Plan:
- Single frame: 243 words 0x00..0xF2 with last on 0xF2, i_out_ready=1 → 243 contiguous o_enb, o_data 0x00..0xF2, o_last only on 0xF2, o_frame_len=243, o_err_ovf never set.
- Overlap: two back-to-back 10-word frames (0x10.. and 0x20..), valid held high → second frame accepted while the first is sending. Output 0x10..0x19 then 0x20..0x29. o_tready low for at most 2 cycles between frames.
- Backpressure: 5-word frame, i_out_ready toggling 1,0,0,1,... → o_data/o_enb stable during stalls, each word delivered exactly once in order. Three 5-word frames sent with i_out_ready=0 → o_tready=0 after two commits.
- Overflow with MAX_WORDS=4: 6-word frame A..F, last on F → o_err_ovf pulses once, output A,B,C,D with o_last on D, o_frame_len=4. An exact 4-word frame → no error.
- Reset: assert i_rst_n=0 mid-load (word 3 of 8) and mid-send → all outputs 0 immediately. After release, a new 2-word frame 0xAA,0xBB outputs exactly 0xAA,0xBB.
- With TASK_IN_FRAME_CNT_EN: send 3 frames, one overflowing → o_frame_cnt=3, o_ovf_cnt=1.

Source files
------------

// File: rtl/task_in_pingpong.sv
// task_in_pingpong: ping-pong input stage for the task core.
// Input frames are captured into one of two banks while the other bank
// replays its completed frame downstream with valid/ready handshaking.
// Frames longer than MAX_WORDS are truncated, and each truncation raises a
// one-cycle o_err_ovf pulse.
// Optional build macro TASK_IN_FRAME_CNT_EN adds o_frame_cnt (frames fully
// sent, wrapping) and o_ovf_cnt (truncations, saturating).
module task_in_pingpong #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WORDS  = 243,
  parameter int LEN_WIDTH  = $clog2(MAX_WORDS + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_tdata_valid,
  input  logic [DATA_WIDTH-1:0] i_tdata,
  input  logic                  i_tdata_last,
  output logic                  o_tready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_enb,
  output logic                  o_last,
  input  logic                  i_out_ready,
  output logic [LEN_WIDTH-1:0]  o_frame_len,
  output logic                  o_err_ovf
`ifdef TASK_IN_FRAME_CNT_EN
  ,
  output logic [15:0]           o_frame_cnt,
  output logic [7:0]            o_ovf_cnt
`endif
);

  localparam int ADDR_WIDTH = $clog2(2 * MAX_WORDS);

  typedef enum logic [1:0] {W_IDLE, W_LOAD, W_DROP} w_state_e;
  typedef enum logic       {R_IDLE, R_SEND}         r_state_e;

  // Bank 0 occupies [0, MAX_WORDS), bank 1 occupies [MAX_WORDS, 2*MAX_WORDS).
  function automatic logic [ADDR_WIDTH-1:0] bank_addr(input logic bank,
                                                      input logic [LEN_WIDTH-1:0] idx);
    return bank ? ADDR_WIDTH'(MAX_WORDS) + ADDR_WIDTH'(idx) : ADDR_WIDTH'(idx);
  endfunction

  logic [DATA_WIDTH-1:0] mem [2*MAX_WORDS];

  logic [1:0]            full_q;
  logic [LEN_WIDTH-1:0]  len_q [2];

  w_state_e              w_state_q;
  logic                  wr_bank_q;
  logic [LEN_WIDTH-1:0]  wr_cnt_q;
  logic                  tready_q;
  logic                  err_ovf_q;

  r_state_e              r_state_q;
  logic                  rd_bank_q;
  logic [LEN_WIDTH-1:0]  rd_idx_q;
  logic [LEN_WIDTH-1:0]  frame_len_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  enb_q;
  logic                  last_q;

  logic                  wr_accept;
  logic                  wr_store;
  logic                  commit;
  logic [LEN_WIDTH-1:0]  commit_len;
  logic                  rd_xfer;
  logic                  bank_release;
  logic [LEN_WIDTH-1:0]  rd_next;

  // Handshake decode shared by the bank flags, the memory and both FSMs.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    commit     = 1'b0;
    commit_len = wr_cnt_q + 1'b1;
    wr_accept  = i_tdata_valid && tready_q;
    wr_store   = wr_accept && (w_state_q == W_LOAD);
    if (wr_accept && i_tdata_last) begin
      if (w_state_q == W_LOAD) begin
        commit = 1'b1;
      end else if (w_state_q == W_DROP) begin
        commit     = 1'b1;
        commit_len = LEN_WIDTH'(MAX_WORDS);
      end
    end
    rd_xfer      = enb_q && i_out_ready;
    bank_release = rd_xfer && last_q;
    rd_next      = rd_idx_q + 1'b1;
  end

  // Bank full flags and stored lengths: the writer commits, the reader releases.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!i_rst_n) begin
      full_q   <= '0;
      len_q[0] <= '0;
      len_q[1] <= '0;
    end else begin
      if (bank_release) full_q[rd_bank_q] <= 1'b0;
      if (commit) begin
        full_q[wr_bank_q] <= 1'b1;
        len_q[wr_bank_q]  <= commit_len;
      end
    end
  end

  // Frame storage written by the load side.
  // NOTE: the data array has no reset; the full flags alone decide what is valid, so it can map to RAM.
  always_ff @(posedge i_clk) begin
    if (wr_store) mem[bank_addr(wr_bank_q, wr_cnt_q)] <= i_tdata;
  end

  // Write FSM: wait for a free bank, load words, drop the excess of long frames.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      w_state_q <= W_IDLE;
      wr_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      tready_q  <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      err_ovf_q <= 1'b0;
      case (w_state_q)
        W_IDLE: begin
          if (!full_q[wr_bank_q]) begin
            w_state_q <= W_LOAD;
            wr_cnt_q  <= '0;
            tready_q  <= 1'b1;
          end
        end
        W_LOAD: begin
          if (wr_accept) begin
            if (i_tdata_last) begin
              w_state_q <= W_IDLE;
              tready_q  <= 1'b0;
              wr_bank_q <= ~wr_bank_q;
            end else if (wr_cnt_q == LEN_WIDTH'(MAX_WORDS - 1)) begin
              w_state_q <= W_DROP;
            end else begin
              wr_cnt_q <= wr_cnt_q + 1'b1;
            end
          end
        end
        W_DROP: begin
          if (wr_accept && i_tdata_last) begin
            w_state_q <= W_IDLE;
            tready_q  <= 1'b0;
            err_ovf_q <= 1'b1;
            wr_bank_q <= ~wr_bank_q;
          end
        end
        default: begin
          w_state_q <= W_IDLE;
          tready_q  <= 1'b0;
        end
      endcase
    end
  end

  // Read FSM: replay a full bank word by word, holding outputs while stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state_q   <= R_IDLE;
      rd_bank_q   <= 1'b0;
      rd_idx_q    <= '0;
      frame_len_q <= '0;
      data_q      <= '0;
      enb_q       <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (full_q[rd_bank_q]) begin
            r_state_q   <= R_SEND;
            frame_len_q <= len_q[rd_bank_q];
            rd_idx_q    <= '0;
            data_q      <= mem[bank_addr(rd_bank_q, '0)];
            enb_q       <= 1'b1;
            last_q      <= (len_q[rd_bank_q] == LEN_WIDTH'(1));
          end
        end
        R_SEND: begin
          if (rd_xfer) begin
            if (last_q) begin
              r_state_q <= R_IDLE;
              enb_q     <= 1'b0;
              last_q    <= 1'b0;
              rd_bank_q <= ~rd_bank_q;
            end else begin
              rd_idx_q <= rd_next;
              data_q   <= mem[bank_addr(rd_bank_q, rd_next)];
              last_q   <= (rd_next == frame_len_q - 1'b1);
            end
          end
        end
        default: begin
          r_state_q <= R_IDLE;
          enb_q     <= 1'b0;
          last_q    <= 1'b0;
        end
      endcase
    end
  end

  assign o_tready    = tready_q;
  assign o_data      = data_q;
  assign o_enb       = enb_q;
  assign o_last      = last_q;
  assign o_frame_len = frame_len_q;
  assign o_err_ovf   = err_ovf_q;

`ifdef TASK_IN_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  ovf_cnt_q;

  // Statistics: frames fully sent (wrapping) and truncations (saturating).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_cnt_q <= '0;
      ovf_cnt_q   <= '0;
    end else begin
      if (bank_release) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (err_ovf_q && (ovf_cnt_q != 8'hFF)) ovf_cnt_q <= ovf_cnt_q + 8'd1;
    end
  end

  assign o_frame_cnt = frame_cnt_q;
  assign o_ovf_cnt   = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_task_in_pingpong.sv
// tb_task_in_pingpong: directed bench for task_in_pingpong.
// Two instances: u_big (MAX_WORDS=243) and u_small (MAX_WORDS=4) for truncation.
// sel steers the shared stimulus to one instance and muxes its outputs back.
module tb_task_in_pingpong;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, sel, valid, last_in, out_ready;
  logic [7:0] data_in;
  logic       b_valid, s_valid;
  assign b_valid = valid & ~sel;
  assign s_valid = valid & sel;

  logic       b_tready, b_enb, b_last, b_err;
  logic [7:0] b_data, b_len;
  logic       s_tready, s_enb, s_last, s_err;
  logic [7:0] s_data;
  logic [2:0] s_len;
`ifdef TASK_IN_FRAME_CNT_EN
  logic [15:0] b_fcnt, s_fcnt;
  logic [7:0]  b_ocnt, s_ocnt;
`endif

  task_in_pingpong #(.DATA_WIDTH(8), .MAX_WORDS(243)) u_big (
    .i_clk(clk), .i_rst_n(rst_n), .i_tdata_valid(b_valid), .i_tdata(data_in),
    .i_tdata_last(last_in), .o_tready(b_tready), .o_data(b_data), .o_enb(b_enb),
    .o_last(b_last), .i_out_ready(out_ready), .o_frame_len(b_len), .o_err_ovf(b_err)
`ifdef TASK_IN_FRAME_CNT_EN
    , .o_frame_cnt(b_fcnt), .o_ovf_cnt(b_ocnt)
`endif
  );

  task_in_pingpong #(.DATA_WIDTH(8), .MAX_WORDS(4)) u_small (
    .i_clk(clk), .i_rst_n(rst_n), .i_tdata_valid(s_valid), .i_tdata(data_in),
    .i_tdata_last(last_in), .o_tready(s_tready), .o_data(s_data), .o_enb(s_enb),
    .o_last(s_last), .i_out_ready(out_ready), .o_frame_len(s_len), .o_err_ovf(s_err)
`ifdef TASK_IN_FRAME_CNT_EN
    , .o_frame_cnt(s_fcnt), .o_ovf_cnt(s_ocnt)
`endif
  );

  logic       m_tready, m_enb, m_last, m_err;
  logic [7:0] m_data, m_len;
  assign m_tready = sel ? s_tready : b_tready;
  assign m_enb    = sel ? s_enb    : b_enb;
  assign m_last   = sel ? s_last   : b_last;
  assign m_err    = sel ? s_err    : b_err;
  assign m_data   = sel ? s_data   : b_data;
  assign m_len    = sel ? {5'd0, s_len} : b_len;

  int total = 0;
  int bad   = 0;

  // Overflow pulses on the selected instance, counted away from the clock edge.
  int err_cnt = 0;
  always @(negedge clk) if (m_err === 1'b1) err_cnt <= err_cnt + 1;

  // Sender bookkeeping.
  int  first_wait;
  time first_acc_t, last_acc_t;
  bit  push_to;

  // Collector bookkeeping.
  logic [7:0] rx_data[$];
  bit         rx_last[$];
  logic [7:0] rx_len[$];
  time        rx_time[$];
  int         stall_cnt, stall_bad;

  // Present one word and wait (bounded) until it is accepted.
  task automatic push(input logic [7:0] d, input logic l, output int w);
    valid = 1'b1; data_in = d; last_in = l; w = 0;
    while (m_tready !== 1'b1 && w < 2000) begin @(posedge clk); #1; w++; end
    if (w >= 2000) push_to = 1'b1;
    last_acc_t = $time;
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [7:0] base, input logic [7:0] step, input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      push(base + 8'(i) * step, (i == n - 1), w);
      if (i == 0) begin first_wait = w; first_acc_t = last_acc_t; end
    end
    valid = 1'b0; last_in = 1'b0;
  endtask

  // Receive up to n words. mode 0: always ready; mode 1: ready on every third cycle.
  task automatic collect(input int n, input int mode, input int budget);
    int cyc; logic pe, pr, pl; logic [7:0] pd;
    rx_data.delete(); rx_last.delete(); rx_len.delete(); rx_time.delete();
    stall_cnt = 0; stall_bad = 0; cyc = 0; pe = 1'b0; pr = 1'b1; pd = '0; pl = 1'b0;
    while (rx_data.size() < n && cyc < budget) begin
      out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      if (pe && !pr) begin
        stall_cnt++;
        if (m_enb !== 1'b1 || m_data !== pd || m_last !== pl) stall_bad++;
      end
      if (m_enb === 1'b1 && out_ready) begin
        rx_data.push_back(m_data); rx_last.push_back(m_last);
        rx_len.push_back(m_len);   rx_time.push_back($time);
      end
      pe = m_enb; pr = out_ready; pd = m_data; pl = m_last;
      @(posedge clk); #1; cyc++;
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    sel = 1'b0; valid = 1'b0; last_in = 1'b0; data_in = '0; out_ready = 1'b1; rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    total++;
    if ({b_tready, b_enb, b_last, b_err, b_data, b_len} !== 20'd0) begin
      bad++; $display("FAIL reset_big outputs=%h expected 0", {b_tready, b_enb, b_last, b_err, b_data, b_len});
    end
    total++;
    if ({s_tready, s_enb, s_last, s_err, s_data, s_len} !== 15'd0) begin
      bad++; $display("FAIL reset_small outputs=%h expected 0", {s_tready, s_enb, s_last, s_err, s_data, s_len});
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (m_tready !== 1'b1) begin bad++; $display("FAIL tready_after_reset got=%b exp=1", m_tready); end
  endtask

  task automatic test_single_frame();
    int e0;
    e0 = err_cnt; push_to = 1'b0;
    fork
      send_frame(8'h00, 8'h01, 243);
      collect(243, 0, 3000);
    join
    total++;
    if (rx_data.size() != 243 || push_to) begin
      bad++; $display("FAIL single_count got=%0d exp=243 push_timeout=%0d", rx_data.size(), push_to);
    end
    for (int i = 0; i < rx_data.size(); i++) begin
      total++;
      if (rx_data[i] !== 8'(i) || rx_last[i] !== (i == 242) || rx_len[i] !== 8'd243) begin
        bad++; $display("FAIL single_word[%0d] got data=%h last=%b len=%0d exp data=%h last=%b len=243",
                        i, rx_data[i], rx_last[i], rx_len[i], 8'(i), (i == 242));
      end
    end
    total++;
    if (rx_data.size() == 243 && (rx_time[242] - rx_time[0]) != 242 * 10) begin
      bad++; $display("FAIL single_contiguous span=%0t exp=2420", rx_time[242] - rx_time[0]);
    end
    total++;
    if (err_cnt - e0 != 0) begin bad++; $display("FAIL single_no_ovf pulses=%0d exp=0", err_cnt - e0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    push_to = 1'b0;
    fork
      begin send_frame(8'h10, 8'h01, 10); send_frame(8'h20, 8'h01, 10); end
      collect(20, 0, 500);
    join
    total++;
    if (rx_data.size() != 20 || push_to) begin
      bad++; $display("FAIL overlap_count got=%0d exp=20 push_timeout=%0d", rx_data.size(), push_to);
    end
    for (int i = 0; i < rx_data.size(); i++) begin
      exp = (i < 10) ? 8'h10 + 8'(i) : 8'h20 + 8'(i - 10);
      total++;
      if (rx_data[i] !== exp || rx_last[i] !== (i == 9 || i == 19) || rx_len[i] !== 8'd10) begin
        bad++; $display("FAIL overlap_word[%0d] got data=%h last=%b len=%0d exp data=%h last=%b len=10",
                        i, rx_data[i], rx_last[i], rx_len[i], exp, (i == 9 || i == 19));
      end
    end
    total++;
    if (first_wait > 2) begin bad++; $display("FAIL overlap_tready_gap got=%0d cycles exp<=2", first_wait); end
    if (rx_data.size() == 20) begin
      total++;
      if (first_acc_t >= rx_time[9]) begin
        bad++; $display("FAIL overlap_concurrent frame2_accept=%0t frame1_end=%0t", first_acc_t, rx_time[9]);
      end
      total++;
      if (rx_time[10] - rx_time[9] > 30) begin
        bad++; $display("FAIL overlap_next_enb gap=%0t exp<=30", rx_time[10] - rx_time[9]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit lo;
    logic [7:0] exp;
    push_to = 1'b0;
    fork
      send_frame(8'h40, 8'h01, 5);
      collect(5, 1, 500);
    join
    total++;
    if (rx_data.size() != 5) begin bad++; $display("FAIL bp_count got=%0d exp=5", rx_data.size()); end
    for (int i = 0; i < rx_data.size(); i++) begin
      total++;
      if (rx_data[i] !== 8'h40 + 8'(i) || rx_last[i] !== (i == 4)) begin
        bad++; $display("FAIL bp_word[%0d] got data=%h last=%b exp data=%h last=%b",
                        i, rx_data[i], rx_last[i], 8'h40 + 8'(i), (i == 4));
      end
    end
    total++;
    if (stall_cnt == 0 || stall_bad != 0) begin
      bad++; $display("FAIL bp_stall_hold stalls=%0d unstable=%0d exp stalls>0 unstable=0", stall_cnt, stall_bad);
    end
    // Both banks fill while the sink refuses.
    out_ready = 1'b0;
    send_frame(8'h50, 8'h01, 5);
    send_frame(8'h60, 8'h01, 5);
    lo = 1'b1;
    repeat (4) begin if (m_tready !== 1'b0) lo = 1'b0; @(posedge clk); #1; end
    total++;
    if (!lo || push_to) begin bad++; $display("FAIL bp_both_full tready_low=%0d exp=1 push_timeout=%0d", lo, push_to); end
    total++;
    if (m_enb !== 1'b1 || m_data !== 8'h50) begin
      bad++; $display("FAIL bp_held_head got enb=%b data=%h exp enb=1 data=50", m_enb, m_data);
    end
    fork
      send_frame(8'h70, 8'h01, 5);
      collect(15, 0, 500);
    join
    total++;
    if (rx_data.size() != 15 || push_to) begin
      bad++; $display("FAIL bp3_count got=%0d exp=15 push_timeout=%0d", rx_data.size(), push_to);
    end
    for (int i = 0; i < rx_data.size(); i++) begin
      exp = 8'h50 + 8'((i / 5) * 16 + (i % 5));
      total++;
      if (rx_data[i] !== exp || rx_last[i] !== (i % 5 == 4)) begin
        bad++; $display("FAIL bp3_word[%0d] got data=%h last=%b exp data=%h last=%b",
                        i, rx_data[i], rx_last[i], exp, (i % 5 == 4));
      end
    end
  endtask

  task automatic test_overflow();
    int e0;
    sel = 1'b1; push_to = 1'b0; e0 = err_cnt;
    fork
      send_frame(8'h0A, 8'h01, 6);
      collect(4, 0, 200);
    join
    repeat (3) @(posedge clk); #1;
    total++;
    if (rx_data.size() != 4 || push_to) begin
      bad++; $display("FAIL ovf_count got=%0d exp=4 push_timeout=%0d", rx_data.size(), push_to);
    end
    for (int i = 0; i < rx_data.size(); i++) begin
      total++;
      if (rx_data[i] !== 8'h0A + 8'(i) || rx_last[i] !== (i == 3) || rx_len[i] !== 8'd4) begin
        bad++; $display("FAIL ovf_word[%0d] got data=%h last=%b len=%0d exp data=%h last=%b len=4",
                        i, rx_data[i], rx_last[i], rx_len[i], 8'h0A + 8'(i), (i == 3));
      end
    end
    total++;
    if (err_cnt - e0 != 1) begin bad++; $display("FAIL ovf_pulse got=%0d exp=1", err_cnt - e0); end
    // Exact fill: last on word MAX_WORDS is not an error.
    e0 = err_cnt;
    fork
      send_frame(8'h21, 8'h01, 4);
      collect(4, 0, 200);
    join
    repeat (3) @(posedge clk); #1;
    total++;
    if (rx_data.size() != 4 || err_cnt - e0 != 0) begin
      bad++; $display("FAIL exact_fill got count=%0d pulses=%0d exp count=4 pulses=0", rx_data.size(), err_cnt - e0);
    end
    for (int i = 0; i < rx_data.size(); i++) begin
      total++;
      if (rx_data[i] !== 8'h21 + 8'(i) || rx_last[i] !== (i == 3) || rx_len[i] !== 8'd4) begin
        bad++; $display("FAIL exact_word[%0d] got data=%h last=%b len=%0d exp data=%h last=%b len=4",
                        i, rx_data[i], rx_last[i], rx_len[i], 8'h21 + 8'(i), (i == 3));
      end
    end
  endtask

  task automatic test_reset_mid();
    int w, k;
    bit quiet;
    sel = 1'b0; out_ready = 1'b1;
    // Mid-load: three words in, fourth presented.
    for (int i = 0; i < 3; i++) push(8'(i), 1'b0, w);
    valid = 1'b1; data_in = 8'h03; last_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({m_tready, m_enb, m_last, m_err, m_data, m_len} !== 20'd0) begin
      bad++; $display("FAIL reset_mid_load outputs=%h expected 0", {m_tready, m_enb, m_last, m_err, m_data, m_len});
    end
    valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    // Mid-send: frame waits at the output.
    out_ready = 1'b0;
    send_frame(8'h30, 8'h01, 4);
    k = 0;
    while (m_enb !== 1'b1 && k < 10) begin @(posedge clk); #1; k++; end
    total++;
    if (m_enb !== 1'b1 || m_len !== 8'd4) begin
      bad++; $display("FAIL reset_mid_pending got enb=%b len=%0d exp enb=1 len=4", m_enb, m_len);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({m_tready, m_enb, m_last, m_err, m_data, m_len} !== 20'd0) begin
      bad++; $display("FAIL reset_mid_send outputs=%h expected 0", {m_tready, m_enb, m_last, m_err, m_data, m_len});
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    push_to = 1'b0;
    fork
      send_frame(8'hAA, 8'h11, 2);
      collect(2, 0, 100);
    join
    total++;
    if (rx_data.size() != 2 || rx_data[0] !== 8'hAA || rx_data[1] !== 8'hBB ||
        rx_last[0] !== 1'b0 || rx_last[1] !== 1'b1) begin
      bad++; $display("FAIL reset_recover got count=%0d d0=%h d1=%h exp count=2 d0=aa d1=bb",
                      rx_data.size(), rx_data[0], rx_data[1]);
    end
    quiet = 1'b1;
    repeat (10) begin if (m_enb !== 1'b0) quiet = 1'b0; @(posedge clk); #1; end
    total++;
    if (!quiet) begin bad++; $display("FAIL reset_no_stale got extra output exp none"); end
  endtask

`ifdef TASK_IN_FRAME_CNT_EN
  task automatic test_frame_cnt();
    sel = 1'b1; out_ready = 1'b1;
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    fork send_frame(8'h01, 8'h01, 2); collect(2, 0, 100); join
    fork send_frame(8'h11, 8'h01, 6); collect(4, 0, 100); join
    fork send_frame(8'h21, 8'h01, 3); collect(3, 0, 100); join
    repeat (3) @(posedge clk); #1;
    total++;
    if (s_fcnt !== 16'd3 || s_ocnt !== 8'd1) begin
      bad++; $display("FAIL frame_cnt got frames=%0d ovf=%0d exp frames=3 ovf=1", s_fcnt, s_ocnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_reset_mid();
`ifdef TASK_IN_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
